// File: rtl/fsqrt_issue.sv
// Single-precision square-root issue stage: holds one operand on a combinational
// fsqrt core for LATENCY cycles, then queues {y, exc, tag} in a 2-entry result FIFO.

module fsqrt_core (
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic        exception
);
    logic        sgn;
    logic [7:0]  e;
    logic [22:0] f;
    logic [47:0] rad;
    logic [23:0] root;
    logic [27:0] rem;
    logic [27:0] trial;
    logic [7:0]  ey;

    assign sgn = x[31];
    assign e   = x[30:23];
    assign f   = x[22:0];

    // Odd biased exponent means an even unbiased exponent; otherwise the
    // mantissa is doubled so the halved exponent stays integral.
    always_comb begin
        rad = e[0] ? {2'b01, f, 23'd0} : {1'b1, f, 24'd0};
        ey  = 8'(({1'b0, e} + 9'd126 + {8'd0, e[0]}) >> 1);
    end

    // Restoring digit recurrence, one root bit per step; result is truncated.
    always_comb begin
        rem   = '0;
        root  = '0;
        trial = '0;
        for (int i = 23; i >= 0; i--) begin
            rem   = {rem[25:0], rad[2*i+1], rad[2*i]};
            trial = {2'b00, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[22:0], 1'b1};
            end else begin
                root = {root[22:0], 1'b0};
            end
        end
    end

    // Any negative input (including -0) and any NaN raise the exception;
    // subnormal inputs are flushed to a zero result.
    always_comb begin
        y         = 32'd0;
        exception = 1'b0;
        if (sgn || (e == 8'hFF && f != 23'd0)) begin
            y         = 32'h7FC00000;
            exception = 1'b1;
        end else if (e == 8'hFF) begin
            y = 32'h7F800000;
        end else if (e == 8'd0) begin
            y = 32'd0;
        end else begin
            y = {1'b0, ey, root[22:0]};
        end
    end
endmodule

module fsqrt_issue #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_exc,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int         EW   = 33 + TAG_W;
    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    typedef enum logic {IDLE, EVAL} state_t;

    state_t           state, state_d;
    logic [3:0]       cnt, cnt_d;
    logic [31:0]      x_r;
    logic [TAG_W-1:0] tag_r;
    logic [31:0]      core_y;
    logic             core_exc;

    logic [EW-1:0]    mem [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;
    logic [EW-1:0]    head;

    logic             accept, done, push, pop;

    fsqrt_core u_core (
        .x         (x_r),
        .y         (core_y),
        .exception (core_exc)
    );

    // Valid/ready: a transfer happens on a rising edge where both valid and
    // ready are high; ready never depends on valid, and flush cancels transfers.
    assign in_ready  = !rst && (state == IDLE) && (count < 2'd2) && !flush;
    assign accept    = in_valid && in_ready;
    assign done      = (state == EVAL) && (cnt == LAST);
    assign out_valid = (count != 2'd0);
    assign push      = done && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign busy      = (state == EVAL) || (count != 2'd0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_d = EVAL;
                        cnt_d   = 4'd0;
                    end
                end
                EVAL: begin
                    if (done) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r   <= 32'd0;
            tag_r <= '0;
        end else if (accept) begin
            x_r   <= in_x;
            tag_r <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {core_y, core_exc, tag_r};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign head    = mem[rd_ptr];
    assign out_y   = out_valid ? head[EW-1 -: 32] : 32'd0;
    assign out_exc = out_valid ? head[TAG_W] : 1'b0;
    assign out_tag = out_valid ? head[TAG_W-1:0] : '0;
endmodule

// File: tb/tb_fsqrt_issue.sv
// Bench for fsqrt_issue: queue-based reference of the issue/FIFO behaviour plus
// a real-arithmetic square-root reference, checked every cycle on the falling edge.

module tb_fsqrt_issue;
    localparam int LATENCY = 2;
    localparam int TAG_W   = 6;
    localparam int QW      = 32 + TAG_W;
    localparam int N_SWEEP = 508;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_x = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_y;
    logic             out_exc;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    bit sweep_on = 1'b0;
    int dut_pops = 0;

    fsqrt_issue #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_exc   (out_exc),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference helpers ----------------
    function automatic real f2r(input logic [31:0] v);
        int  e;
        real m;
        e = int'(v[30:23]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(v[22:0]) / 8388608.0;
        m = m * (2.0 ** (e - 127));
        return v[31] ? -m : m;
    endfunction

    function automatic bit exc_of(input logic [31:0] x);
        return x[31] || (x[30:23] == 8'hFF && x[22:0] != 23'd0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_y(input string nm, input logic [31:0] x, input logic [31:0] y);
        real r, a, bound;
        n_tests++;
        bound = 1.0 / 1048576.0;
        if (x[30:23] == 8'hFF) begin
            if (y !== 32'h7F800000) begin
                n_fail++;
                $display("FAIL %s: x=%h got %h expected 7f800000", nm, x, y);
            end
        end else if (x[30:23] != 8'd0) begin
            r = $sqrt(f2r(x));
            a = f2r(y);
            if (y[31] || y[30:23] == 8'd0 || y[30:23] == 8'hFF ||
                (a - r) / r > bound || (r - a) / r > bound) begin
                n_fail++;
                $display("FAIL %s: x=%h got %h (%g) expected %g", nm, x, y, a, r);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [QW-1:0] exp_q[$];
    bit            m_pend = 1'b0;
    int            m_left = 0;
    logic [QW-1:0] m_op = '0;
    bit            m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_left = 0;
        end else if (flush) begin
            exp_q.delete();
            m_pend = 1'b0;
        end else begin
            m_acc = in_valid && !m_pend && (exp_q.size() < 2);
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (m_pend) begin
                if (m_left == 1) begin
                    exp_q.push_back(m_op);
                    m_pend = 1'b0;
                end else begin
                    m_left--;
                end
            end
            if (m_acc) begin
                m_pend = 1'b1;
                m_left = LATENCY;
                m_op   = {in_x, in_tag};
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [QW-1:0] hd;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", 32'(in_ready), 32'(!rst && !m_pend && exp_q.size() < 2 && !flush));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("busy", 32'(busy), 32'(m_pend || exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                hd = exp_q[0];
                chk("out_tag", 32'(out_tag), 32'(hd[TAG_W-1:0]));
                chk("out_exc", 32'(out_exc), 32'(exc_of(hd[QW-1 -: 32])));
                if (!exc_of(hd[QW-1 -: 32])) chk_y("out_y", hd[QW-1 -: 32], out_y);
            end else begin
                chk("idle_out_y", out_y, 32'd0);
                chk("idle_out_exc", 32'(out_exc), 32'd0);
                chk("idle_out_tag", 32'(out_tag), 32'd0);
            end
            if (sweep_on && out_valid && out_ready) dut_pops++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] x, input logic [TAG_W-1:0] tag);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_tag   = tag;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: x=%h not accepted in 50 cycles", x);
        end
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: out_valid got 0 expected 1 within 20 cycles", nm);
        end
    endtask

    // ---------------- stimulus ----------------
    int  idx;
    int  cyc;
    bit  rdy_s;

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // pin the reference itself
        n_tests++;
        if ($sqrt(f2r(32'h41800000)) != 4.0 || f2r(32'h40400000) != 3.0) begin
            n_fail++;
            $display("FAIL ref_pin: sqrt(16)=%g expected 4, dec(40400000)=%g expected 3",
                     $sqrt(f2r(32'h41800000)), f2r(32'h40400000));
        end

        // sqrt(4.0), one-cycle result with out_ready high
        out_ready = 1'b1;
        issue(32'h40800000, 6'd5);
        @(negedge clk); chk("lat_edge0_valid", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);
        chk("sqrt4_y", out_y, 32'h40000000);
        chk("sqrt4_exc", 32'(out_exc), 32'd0);
        chk("sqrt4_tag", 32'(out_tag), 32'd5);
        @(negedge clk); chk("sqrt4_one_cycle", 32'(out_valid), 32'd0);

        // sqrt(-1.0) raises exception
        issue(32'hBF800000, 6'd3);
        wait_valid("neg_wait");
        chk("neg_exc", 32'(out_exc), 32'd1);
        chk("neg_tag", 32'(out_tag), 32'd3);
        issue(32'h80000000, 6'd4);
        wait_valid("negzero_wait");
        chk("negzero_exc", 32'(out_exc), 32'd1);

        // FIFO fills to two with back-pressure, drains in order
        @(posedge clk); #1 out_ready = 1'b0;
        issue(32'h41100000, 6'd7);
        issue(32'h41800000, 6'd8);
        repeat (4) @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_y", out_y, 32'h40400000);
        chk("full_head_tag", 32'(out_tag), 32'd7);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk); chk("drain0_y", out_y, 32'h40400000);
        @(negedge clk); chk("drain1_y", out_y, 32'h40800000);
        chk("drain1_tag", 32'(out_tag), 32'd8);
        @(negedge clk); chk("drain_empty", 32'(out_valid), 32'd0);

        // reset in the middle of an evaluation
        issue(32'h40800000, 6'd9);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(out_valid), 32'd0);
        end
        issue(32'h41800000, 6'd10);
        wait_valid("postrst_wait");
        chk("postrst_y", out_y, 32'h40800000);
        chk("postrst_tag", 32'(out_tag), 32'd10);

        // flush with a queued result and a coinciding request
        @(posedge clk); #1 out_ready = 1'b0;
        issue(32'h41100000, 6'd11);
        wait_valid("flush_wait");
        @(posedge clk); #1;
        in_valid = 1'b1; in_x = 32'h40800000; in_tag = 6'd12; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;

        // sweep of every exponent, both signs, random back-pressure
        sweep_on = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < N_SWEEP && cyc < 20000) begin
            @(negedge clk);
            rdy_s = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (in_valid && rdy_s) begin
                idx++;
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && idx < N_SWEEP && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_x     = {idx[0], 8'(idx / 2 + 1), 23'($urandom)};
                in_tag   = idx[TAG_W-1:0];
            end
        end
        in_valid = 1'b0;
        if (idx < N_SWEEP) begin
            n_tests++;
            n_fail++;
            $display("FAIL sweep_timeout: issued %0d expected %0d", idx, N_SWEEP);
        end
        out_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("sweep_drained", 32'(busy), 32'd0);
        chk("sweep_pop_count", 32'(dut_pops), 32'(N_SWEEP));
        sweep_on = 1'b0;
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
